// File: rtl/shift_operand_ctrl_if.sv
// Bundle of decode request, register-file read port, shifter port and op2 result signals.
// The controller uses the slave modport; the surrounding datapath (or a bench) uses master.
interface shift_operand_ctrl_if;
    logic        start;
    logic        imm_flag;
    logic [11:0] operand2;
    logic        carry_in;
    logic        reg_rd_en;
    logic [3:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic [2:0]  sh_op;
    logic [31:0] sh_data;
    logic [7:0]  sh_num;
    logic [31:0] sh_out;
    logic        sh_carry;
    logic        busy;
    logic        done;
    logic [31:0] op2_out;
    logic        op2_carry;
    logic        illegal;

    modport master (
        output start, imm_flag, operand2, carry_in, reg_rd_data, sh_out, sh_carry,
        input  reg_rd_en, reg_rd_addr, sh_op, sh_data, sh_num,
        input  busy, done, op2_out, op2_carry, illegal
    );

    modport slave (
        input  start, imm_flag, operand2, carry_in, reg_rd_data, sh_out, sh_carry,
        output reg_rd_en, reg_rd_addr, sh_op, sh_data, sh_num,
        output busy, done, op2_out, op2_carry, illegal
    );
endinterface

// File: rtl/shift_operand_ctrl.sv
// Sequences the shared barrel shifter to build the ARM data-processing op2 and carry-out.
// Optional macro SHIFT_CTRL_IMM_BYPASS_EN: unrotated immediates skip the shifter entirely.
module shift_operand_ctrl #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    shift_operand_ctrl_if.slave bus
);

    if (RD_LAT != 32'd1) begin : g_rd_lat_bad
        $error("shift_operand_ctrl: only RD_LAT == 1 is supported");
    end

    typedef enum logic [2:0] {StIdle, StRdRs, StRdRm, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [11:0] op_q, op_d;
    logic        imm_q, imm_d;
    logic        cin_q, cin_d;
    logic [7:0]  amt_q, amt_d;
    logic [31:0] op2_out_q, op2_out_d;
    logic        op2_carry_q, op2_carry_d;

    logic accept;
    logic bypass_hit;
    logic use_cin;

    assign accept = (state_q == StIdle) && bus.start;

`ifdef SHIFT_CTRL_IMM_BYPASS_EN
    assign bypass_hit = bus.imm_flag && (bus.operand2[11:8] == 4'd0);
`else
    assign bypass_hit = 1'b0;
`endif

    // Cases where the shifter leaves carry undefined and the CPSR C flag passes through.
    assign use_cin = (imm_q && (op_q[11:8] == 4'd0)) ||
                     (!imm_q && !op_q[4] && (op_q[6:5] == 2'b00) && (op_q[11:7] == 5'd0)) ||
                     (!imm_q && op_q[4] && (amt_q == 8'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.imm_flag) begin
                        state_d = bypass_hit ? StDone : StShift;
                    end else if (!bus.operand2[4]) begin
                        state_d = StRdRm;
                    end else if (!bus.operand2[7]) begin
                        state_d = StRdRs;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRdRs:  state_d = StRdRm;
            StRdRm:  state_d = StShift;
            StShift: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.reg_rd_en   = 1'b0;
        bus.reg_rd_addr = 4'd0;
        bus.sh_op       = 3'b000;
        bus.sh_data     = 32'd0;
        bus.sh_num      = 8'd0;
        unique case (state_q)
            StRdRs: begin
                bus.reg_rd_en   = 1'b1;
                bus.reg_rd_addr = op_q[11:8];
            end
            StRdRm: begin
                bus.reg_rd_en   = 1'b1;
                bus.reg_rd_addr = op_q[3:0];
            end
            StShift: begin
                if (imm_q) begin
                    bus.sh_op   = 3'b111;
                    bus.sh_data = {24'd0, op_q[7:0]};
                    bus.sh_num  = {3'd0, op_q[11:8], 1'b0};
                end else if (!op_q[4]) begin
                    bus.sh_op   = {op_q[6:5], 1'b0};
                    bus.sh_data = bus.reg_rd_data;
                    bus.sh_num  = {3'd0, op_q[11:7]};
                end else begin
                    bus.sh_op   = {op_q[6:5], 1'b1};
                    bus.sh_data = bus.reg_rd_data;
                    bus.sh_num  = amt_q;
                end
            end
            default: ;
        endcase
        bus.busy    = (state_q != StIdle);
        bus.done    = (state_q == StDone);
        bus.illegal = (state_q == StDone) && !imm_q && op_q[4] && op_q[7];
        bus.op2_out   = op2_out_q;
        bus.op2_carry = op2_carry_q;
    end

    always_comb begin
        op_d        = op_q;
        imm_d       = imm_q;
        cin_d       = cin_q;
        amt_d       = amt_q;
        op2_out_d   = op2_out_q;
        op2_carry_d = op2_carry_q;
        if (accept) begin
            op_d  = bus.operand2;
            imm_d = bus.imm_flag;
            cin_d = bus.carry_in;
            // Direct IDLE->DONE: illegal encodings clear op2, bypassed immediates load imm8.
            if (state_d == StDone) begin
                op2_out_d   = bypass_hit ? {24'd0, bus.operand2[7:0]} : 32'd0;
                op2_carry_d = bypass_hit ? bus.carry_in : 1'b0;
            end
        end
        if ((state_q == StRdRm) && op_q[4]) begin
            amt_d = bus.reg_rd_data[7:0];
        end
        if (state_q == StShift) begin
            op2_out_d   = bus.sh_out;
            op2_carry_d = use_cin ? cin_q : bus.sh_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= 12'd0;
            imm_q       <= 1'b0;
            cin_q       <= 1'b0;
            amt_q       <= 8'd0;
            op2_out_q   <= 32'd0;
            op2_carry_q <= 1'b0;
        end else begin
            op_q        <= op_d;
            imm_q       <= imm_d;
            cin_q       <= cin_d;
            amt_q       <= amt_d;
            op2_out_q   <= op2_out_d;
            op2_carry_q <= op2_carry_d;
        end
    end

endmodule

// File: tb/tb_shift_operand_ctrl.sv
// Scoreboard bench for shift_operand_ctrl with a register-file and barrel-shifter model.
module tb_shift_operand_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_operand_ctrl_if bus();

    shift_operand_ctrl #(.RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SHIFT_CTRL_IMM_BYPASS_EN
    localparam int Rot0Lat = 1;
`else
    localparam int Rot0Lat = 2;
`endif

    logic [31:0] regs [16];

    always @(posedge clk) begin
        if (bus.reg_rd_en) bus.reg_rd_data <= regs[bus.reg_rd_addr];
    end

    // ARM barrel shifter: op = {type, register-style amount}; bit 32 of result is carry-out.
    function automatic logic [32:0] shift_model(input logic [2:0] op, input logic [31:0] d,
                                                input logic [7:0] n);
        int a;
        logic [31:0] o;
        logic c;
        if (!op[0]) begin
            a = int'(n[4:0]);
            unique case (op[2:1])
                2'b00: if (a == 0) begin o = d; c = 1'bx; end
                       else begin o = d << a; c = d[32-a]; end
                2'b01: if (a == 0) begin o = 32'd0; c = d[31]; end
                       else begin o = d >> a; c = d[a-1]; end
                2'b10: if (a == 0) begin o = {32{d[31]}}; c = d[31]; end
                       else begin o = 32'($signed(d) >>> a); c = d[a-1]; end
                default: if (a == 0) begin o = {1'b0, d[31:1]}; c = d[0]; end
                         else begin o = (d >> a) | (d << (32 - a)); c = d[a-1]; end
            endcase
        end else begin
            a = int'(n);
            if (a == 0) begin
                o = d; c = 1'bx;
            end else begin
                unique case (op[2:1])
                    2'b00: if (a < 32) begin o = d << a; c = d[32-a]; end
                           else begin o = 32'd0; c = (a == 32) ? d[0] : 1'b0; end
                    2'b01: if (a < 32) begin o = d >> a; c = d[a-1]; end
                           else begin o = 32'd0; c = (a == 32) ? d[31] : 1'b0; end
                    2'b10: if (a < 32) begin o = 32'($signed(d) >>> a); c = d[a-1]; end
                           else begin o = {32{d[31]}}; c = d[31]; end
                    default: begin
                        a = a % 32;
                        if (a == 0) begin o = d; c = d[31]; end
                        else begin o = (d >> a) | (d << (32 - a)); c = d[a-1]; end
                    end
                endcase
            end
        end
        return {c, o};
    endfunction

    always_comb begin
        {bus.sh_carry, bus.sh_out} = shift_model(bus.sh_op, bus.sh_data, bus.sh_num);
    end

    typedef struct {
        int          id;
        int          done_cyc;
        logic [31:0] op2;
        logic        c;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("t%0d_done_cycle", e.id), cyc, e.done_cyc);
                chk($sformatf("t%0d_op2_out", e.id), bus.op2_out, e.op2);
                chk($sformatf("t%0d_op2_carry", e.id), 32'(bus.op2_carry), 32'(e.c));
                chk($sformatf("t%0d_illegal", e.id), 32'(bus.illegal), 32'(e.ill));
            end
        end
    end

    // Called on a negedge; returns on the following negedge with the inputs scrambled.
    task automatic issue(input int id, input logic imm, input logic [11:0] op, input logic cin,
                         input int lat, input logic [31:0] eo, input logic ec, input logic eil,
                         input bit push);
        bus.imm_flag = imm;
        bus.operand2 = op;
        bus.carry_in = cin;
        bus.start    = 1'b1;
        if (push) sb.push_back('{id, cyc + lat, eo, ec, eil});
        @(negedge clk);
        bus.start    = 1'b0;
        bus.imm_flag = ~imm;
        bus.operand2 = ~op;
        bus.carry_in = ~cin;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        bus.start    = 1'b0;
        bus.imm_flag = 1'b0;
        bus.operand2 = 12'd0;
        bus.carry_in = 1'b0;
        bus.reg_rd_data = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rd_en", 32'(bus.reg_rd_en), 32'd0);
        chk("rst_op2_out", bus.op2_out, 32'd0);
        chk("rst_sh_op", 32'(bus.sh_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Rotated immediate 0xFF ror 8.
        issue(1, 1'b1, 12'h4FF, 1'b0, 2, 32'hFF000000, 1'b1, 1'b0, 1'b1);
        chk("t1_sh_num", 32'(bus.sh_num), 32'd8);
        chk("t1_sh_op", 32'(bus.sh_op), 32'b111);
        chk("t1_sh_data", bus.sh_data, 32'h000000FF);
        drain();

        // Immediate LSR #0 == LSR #32.
        regs[2] = 32'h80000001;
        issue(2, 1'b0, 12'h022, 1'b0, 3, 32'h00000000, 1'b1, 1'b0, 1'b1);
        chk("t2_rd_en", 32'(bus.reg_rd_en), 32'd1);
        chk("t2_rd_addr", 32'(bus.reg_rd_addr), 32'd2);
        drain();

        // Register ASR by zero amount: carry passes through.
        regs[3] = 32'h00000100;
        regs[4] = 32'h12345678;
        issue(3, 1'b0, 12'h354, 1'b1, 4, 32'h12345678, 1'b1, 1'b0, 1'b1);
        chk("t3_rs_addr", 32'(bus.reg_rd_addr), 32'd3);
        @(negedge clk);
        chk("t3_rm_addr", 32'(bus.reg_rd_addr), 32'd4);
        @(negedge clk);
        chk("t3_sh_num", 32'(bus.sh_num), 32'd0);
        chk("t3_sh_op", 32'(bus.sh_op), 32'b101);
        drain();

        // Register LSL by 33.
        regs[3] = 32'd33;
        regs[4] = 32'hFFFFFFFF;
        issue(4, 1'b0, 12'h314, 1'b1, 4, 32'h00000000, 1'b0, 1'b0, 1'b1);
        drain();

        // Immediate LSL #0 keeps C; immediate ROR #1 takes shifter carry.
        regs[5] = 32'hDEADBEEF;
        issue(5, 1'b0, 12'h005, 1'b1, 3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        drain();
        issue(6, 1'b0, 12'h0E5, 1'b0, 3, 32'hEF56DF77, 1'b1, 1'b0, 1'b1);
        drain();

        // Illegal encoding.
        issue(7, 1'b0, 12'h094, 1'b1, 1, 32'h00000000, 1'b0, 1'b1, 1'b1);
        chk("t7_rd_en", 32'(bus.reg_rd_en), 32'd0);
        drain();

        // Start while busy and in DONE must be ignored.
        issue(8, 1'b1, 12'h4FF, 1'b0, 2, 32'hFF000000, 1'b1, 1'b0, 1'b1);
        bus.operand2 = 12'h094;
        bus.imm_flag = 1'b0;
        bus.start    = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        chk("t8_op2_held", bus.op2_out, 32'hFF000000);

        // Reset while in RD_RM.
        regs[3] = 32'h00000004;
        issue(9, 1'b0, 12'h354, 1'b1, 4, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t9_busy", 32'(bus.busy), 32'd0);
        chk("t9_done", 32'(bus.done), 32'd0);
        chk("t9_rd_en", 32'(bus.reg_rd_en), 32'd0);
        chk("t9_op2_out", bus.op2_out, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Unrotated immediate: bypass when enabled, else through the shifter with rotate 0.
        issue(10, 1'b1, 12'h0AB, 1'b1, Rot0Lat, 32'h000000AB, 1'b1, 1'b0, 1'b1);
`ifdef SHIFT_CTRL_IMM_BYPASS_EN
        chk("t10_sh_data_idle", bus.sh_data, 32'd0);
`else
        chk("t10_sh_data", bus.sh_data, 32'h000000AB);
`endif
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
